// File: rtl/oddr_pattern_ctrl_pkg.sv
// Shared types and PRBS7 helper for the ODDR test pattern sequencer.
package oddr_test_pkg;

    typedef enum logic [2:0] {
        CLOCK  = 3'd0,
        STATIC = 3'd1,
        WALK   = 3'd2,
        COUNT  = 3'd3,
        PRBS7  = 3'd4
    } pattern_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    // x^7 + x^6 + 1: new bit enters at bit 0 and is returned in s'[0].
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    function automatic logic pattern_reserved(input logic [2:0] sel);
        return sel > 3'(PRBS7);
    endfunction

endpackage

// File: rtl/oddr_pattern_ctrl_if.sv
// Control/data bundle between the VIO control logic and the ODDR pattern sequencer.
interface oddr_pattern_ctrl_if #(
    parameter int LANES   = 8,
    parameter int BURST_W = 16,
    parameter int GAP_W   = 8
);
    import oddr_test_pkg::*;

    // Level/strobe controls: start is a one-cycle request honoured only in IDLE
    // while enable and locked are both high; config is captured on that edge.
    logic               locked;
    logic               enable;
    logic               start;
    logic [2:0]         pattern_sel;
    logic [BURST_W-1:0] burst_len;
    logic [GAP_W-1:0]   gap_len;
    logic               loop_mode;

    logic [LANES-1:0]   d1;
    logic [LANES-1:0]   d2;
    logic               oe;
    logic               busy;
    logic               done;
    logic               aborted;
    logic               bad_pattern;
    state_e             state;

    modport master (
        output locked, enable, start, pattern_sel, burst_len, gap_len, loop_mode,
        input  d1, d2, oe, busy, done, aborted, bad_pattern, state
    );

    modport slave (
        input  locked, enable, start, pattern_sel, burst_len, gap_len, loop_mode,
        output d1, d2, oe, busy, done, aborted, bad_pattern, state
    );

endinterface

// File: rtl/oddr_pattern_gen.sv
// Registered d1/d2 pattern generator; owns the PRBS7 register.
module oddr_pattern_gen
    import oddr_test_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         pattern,
    input  logic [BURST_W-1:0] beat,
    input  logic               prbs_rst,
    input  logic               prbs_adv,
    input  logic               emit,
    output logic [LANES-1:0]   d1,
    output logic [LANES-1:0]   d2
);

    logic [6:0]       prbs;
    logic [6:0]       prbs_mid;
    logic [6:0]       prbs_nxt;
    logic [LANES-1:0] beat_lanes;
    logic [LANES-1:0] walk;
    logic [31:0]      walk_idx;
    logic [LANES-1:0] d1_n;
    logic [LANES-1:0] d2_n;

    if (LANES <= BURST_W) begin : g_trunc
        assign beat_lanes = beat[LANES-1:0];
    end else begin : g_ext
        assign beat_lanes = {{(LANES-BURST_W){1'b0}}, beat};
    end

    always_comb begin
        prbs_mid = prbs7_step(prbs);
        prbs_nxt = prbs7_step(prbs_mid);
        walk_idx = 32'(beat) % 32'(LANES);
        walk     = LANES'(1) << walk_idx;
        d1_n     = '0;
        d2_n     = '0;
        if (emit) begin
            case (pattern)
                3'(CLOCK):  d1_n = '1;
                3'(STATIC): begin
                    d1_n = '1;
                    d2_n = '1;
                end
                3'(WALK):   d1_n = walk;
                3'(COUNT):  begin
                    d1_n = beat_lanes;
                    d2_n = ~beat_lanes;
                end
                // Two LFSR steps per beat: first bit on the rising edge, second on the falling.
                3'(PRBS7):  begin
                    d1_n = {LANES{prbs_mid[0]}};
                    d2_n = {LANES{prbs_nxt[0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prbs <= PRBS7_SEED;
            d1   <= '0;
            d2   <= '0;
        end else begin
            if (prbs_rst) begin
                prbs <= PRBS7_SEED;
            end else if (prbs_adv) begin
                prbs <= prbs_nxt;
            end
            d1 <= d1_n;
            d2 <= d2_n;
        end
    end

endmodule

// File: rtl/oddr_pattern_ctrl.sv
// Burst/gap sequencer for the ODDR test datapath, gated by clk_wiz locked and enable.
module oddr_pattern_ctrl
    import oddr_test_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int BURST_W = 16,
    parameter int GAP_W   = 8
) (
    input logic               clk,
    input logic               rst_n,
    oddr_pattern_ctrl_if.slave bus
);

    state_e             state;
    state_e             state_n;
    logic [BURST_W-1:0] beat;
    logic [BURST_W-1:0] beat_n;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_cnt_n;
    logic [2:0]         pattern_q;
    logic [BURST_W-1:0] len_q;
    logic [GAP_W-1:0]   gap_q;
    logic               loop_q;
    logic               abort;
    logic               accept;
    logic               active;
    logic               last_beat;
    logic               last_gap;
    logic               emit;
    logic               prbs_rst;
    logic               oe_q;
    logic               busy_q;
    logic               done_q;
    logic               aborted_q;
    logic               bad_q;

    always_comb begin
        state_n   = state;
        beat_n    = beat;
        gap_cnt_n = gap_cnt;
        abort     = 1'b0;
        active    = (state == ARM) || (state == RUN) || (state == GAP);
        last_beat = (beat == len_q - BURST_W'(1));
        last_gap  = (gap_cnt == gap_q - GAP_W'(1));
        unique case (state)
            IDLE: begin
                if (bus.start && bus.enable && bus.locked) begin
                    state_n = ARM;
                end
            end
            ARM: begin
                beat_n  = '0;
                state_n = (len_q != '0) ? RUN : DONE;
            end
            RUN: begin
                // A zero-length gap takes no cycles, so loops go straight back to beat 0.
                if (last_beat) begin
                    if (gap_q != '0) begin
                        state_n   = GAP;
                        gap_cnt_n = '0;
                    end else if (loop_q) begin
                        beat_n = '0;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    beat_n = beat + BURST_W'(1);
                end
            end
            GAP: begin
                if (last_gap) begin
                    if (loop_q) begin
                        state_n = RUN;
                        beat_n  = '0;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (active && !(bus.enable && bus.locked)) begin
            state_n = IDLE;
            abort   = 1'b1;
        end
    end

    assign accept   = (state == IDLE) && (state_n == ARM);
    assign emit     = (state_n == RUN);
    assign prbs_rst = (state == IDLE);

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            gap_cnt   <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            loop_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state   <= state_n;
            beat    <= beat_n;
            gap_cnt <= gap_cnt_n;
            if (accept) begin
                pattern_q <= bus.pattern_sel;
                len_q     <= bus.burst_len;
                gap_q     <= bus.gap_len;
                loop_q    <= bus.loop_mode;
                bad_q     <= pattern_reserved(bus.pattern_sel);
            end
            oe_q      <= (state_n == ARM) || (state_n == RUN) || (state_n == GAP);
            busy_q    <= (state_n != IDLE);
            done_q    <= (state_n == DONE);
            aborted_q <= abort;
        end
    end

    oddr_pattern_gen #(
        .LANES   (LANES),
        .BURST_W (BURST_W)
    ) u_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .pattern  (pattern_q),
        .beat     (beat_n),
        .prbs_rst (prbs_rst),
        .prbs_adv (emit),
        .emit     (emit),
        .d1       (bus.d1),
        .d2       (bus.d2)
    );

    assign bus.oe          = oe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;
    assign bus.bad_pattern = bad_q;
    assign bus.state       = state;

endmodule

// File: tb/tb_oddr_pattern_ctrl.sv
// Directed + randomized checks of oddr_pattern_ctrl against a cycle-indexed behavioural model.
module tb_oddr_pattern_ctrl;
    import oddr_test_pkg::*;

    localparam int LANES   = 8;
    localparam int BURST_W = 16;
    localparam int GAP_W   = 8;
    localparam int W       = 5 + 2 * LANES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic bad_exp = 1'b0;
    bit   prbs_bits [0:4095];
    logic [W-1:0] exp_q[$];

    oddr_pattern_ctrl_if #(.LANES(LANES), .BURST_W(BURST_W), .GAP_W(GAP_W)) bus ();

    oddr_pattern_ctrl #(.LANES(LANES), .BURST_W(BURST_W), .GAP_W(GAP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Pattern data for beat b of the current burst and global beat g since ARM.
    function automatic logic [2*LANES-1:0] beat_data(input int pat, input int b, input int g);
        logic [LANES-1:0] a;
        logic [LANES-1:0] c;
        a = '0;
        c = '0;
        case (pat)
            0: a = '1;
            1: begin a = '1; c = '1; end
            2: a[b % LANES] = 1'b1;
            3: begin a = LANES'(b); c = ~a; end
            4: begin a = {LANES{prbs_bits[7 + 2*g]}}; c = {LANES{prbs_bits[8 + 2*g]}}; end
            default: ;
        endcase
        return {a, c};
    endfunction

    // Expected {busy, oe, done, aborted, bad, d1, d2} at cycle t after start (t=0 is ARM).
    function automatic logic [W-1:0] exp_word(input int pat, input int len, input int gap,
                                              input bit loop, input int kill_t, input bit kill_rst,
                                              input logic bad, input int t);
        int u, p, k;
        logic [2*LANES-1:0] z;
        z = '0;
        if (kill_t >= 0 && t > kill_t) begin
            if (kill_rst)        return '0;
            if (t == kill_t + 1) return {4'b0001, bad, z};
            return {4'b0000, bad, z};
        end
        if (t == 0) return {4'b1100, bad, z};
        if (len == 0) return (t == 1) ? {4'b1010, bad, z} : {4'b0000, bad, z};
        u = t - 1;
        if (loop) begin
            p = len + gap;
            k = u % p;
            if (k < len) return {4'b1100, bad, beat_data(pat, k, (u / p) * len + k)};
            return {4'b1100, bad, z};
        end
        if (u < len)           return {4'b1100, bad, beat_data(pat, u, u)};
        if (u < len + gap)     return {4'b1100, bad, z};
        if (u == len + gap)    return {4'b1010, bad, z};
        return {4'b0000, bad, z};
    endfunction

    function automatic logic [W-1:0] observed();
        return {bus.busy, bus.oe, bus.done, bus.aborted, bus.bad_pattern, bus.d1, bus.d2};
    endfunction

    task automatic check(input string tag, input int t);
        logic [W-1:0] exp;
        logic [W-1:0] obs;
        exp = exp_q.pop_front();
        obs = observed();
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // One start request followed by a cycle-by-cycle comparison. kill_t >= 0 drops enable
    // (or asserts reset when kill_rst) after cycle kill_t; poke re-requests start while busy.
    task automatic run_case(input string tag, input int pat, input int len, input int gap,
                            input bit loop, input int kill_t, input bit kill_rst, input bit poke);
        int ncyc;
        if (kill_t >= 0)    ncyc = kill_t + 3;
        else if (len == 0)  ncyc = 4;
        else                ncyc = len + gap + 4;
        @(negedge clk);
        bus.pattern_sel = 3'(pat);
        bus.burst_len   = BURST_W'(len);
        bus.gap_len     = GAP_W'(gap);
        bus.loop_mode   = loop;
        bus.start       = 1'b1;
        bad_exp         = (pat >= 5);
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            exp_q.push_back(exp_word(pat, len, gap, loop, kill_t, kill_rst, bad_exp, t));
            check(tag, t);
            bus.start = poke && (t == 1) && (kill_t != 0);
            if (t == 0) begin
                // Config must already be latched; scramble the live inputs.
                bus.pattern_sel = 3'($urandom_range(0, 7));
                bus.burst_len   = BURST_W'($urandom_range(0, 20));
                bus.gap_len     = GAP_W'($urandom_range(0, 5));
                bus.loop_mode   = 1'($urandom_range(0, 1));
            end
            if (kill_t >= 0 && t == kill_t) begin
                if (kill_rst) rst_n = 1'b0;
                else          bus.enable = 1'b0;
            end
            if (kill_t >= 0 && t == kill_t + 1) begin
                rst_n      = 1'b1;
                bus.enable = 1'b1;
            end
        end
        if (kill_t >= 0 && kill_rst) bad_exp = 1'b0;
        bus.start = 1'b0;
    endtask

    // start presented with enable or locked low must leave the block idle.
    task automatic start_ignored(input string tag, input logic en, input logic lk);
        @(negedge clk);
        bus.enable      = en;
        bus.locked      = lk;
        bus.start       = 1'b1;
        bus.pattern_sel = 3'd0;
        bus.burst_len   = BURST_W'(4);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
            exp_q.push_back({4'b0000, bad_exp, {(2*LANES){1'b0}}});
            check(tag, t);
        end
        bus.enable = 1'b1;
        bus.locked = 1'b1;
    endtask

    initial begin
        int pat, len, gap, kill, last;
        bit loop, krst;

        for (int k = 0; k < 7; k++) prbs_bits[k] = 1'b1;
        for (int k = 7; k < 4096; k++) prbs_bits[k] = prbs_bits[k-7] ^ prbs_bits[k-6];

        bus.locked      = 1'b1;
        bus.enable      = 1'b1;
        bus.start       = 1'b0;
        bus.pattern_sel = '0;
        bus.burst_len   = '0;
        bus.gap_len     = '0;
        bus.loop_mode   = 1'b0;

        repeat (3) @(negedge clk);
        exp_q.push_back('0);
        check("reset", 0);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back('0);
        check("post_reset", 0);

        run_case("clock_len4",    0, 4,  0, 1'b0, -1, 1'b0, 1'b1);
        run_case("walk_len10",    2, 10, 0, 1'b0, -1, 1'b0, 1'b0);
        run_case("prbs_loop",     4, 4,  0, 1'b1, 128, 1'b0, 1'b1);
        run_case("count_loop_gap",3, 3,  2, 1'b1, 9,  1'b0, 1'b0);
        run_case("len0",          3, 0,  0, 1'b0, -1, 1'b0, 1'b1);
        run_case("reserved6",     6, 5,  1, 1'b0, -1, 1'b0, 1'b0);
        run_case("static_gap",    1, 6,  3, 1'b0, -1, 1'b0, 1'b1);
        start_ignored("locked_low", 1'b1, 1'b0);
        start_ignored("enable_low", 1'b0, 1'b1);
        run_case("reset_mid",     2, 10, 0, 1'b0, 3,  1'b1, 1'b0);

        for (int i = 0; i < 25; i++) begin
            pat  = $urandom_range(0, 7);
            len  = $urandom_range(0, 12);
            gap  = $urandom_range(0, 4);
            loop = 1'($urandom_range(0, 1));
            krst = ($urandom_range(0, 3) == 0);
            if (len == 0)  last = 0;
            else if (loop) last = 40;
            else           last = len + gap;
            if (loop && len != 0)              kill = $urandom_range(0, last);
            else if ($urandom_range(0, 2) == 0) kill = $urandom_range(0, last);
            else                                kill = -1;
            run_case("random", pat, len, gap, loop, kill, krst, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
